// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default geometry for the parametrised FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Pointer width: enough bits to address DEPTH words.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: one extra bit so the value DEPTH is representable.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset; occupancy is tracked by the owner.
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: capture one word per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with almost-full/empty flags, overflow and
// underflow pulses, synchronous flush and optional first-word-fall-through.
//
// Handshake: a write is taken on an edge when wr=1 and there is room, where a
// read accepted on the same edge counts as making room; a read is taken when
// rd=1 and the FIFO holds at least one word. A request that is not taken
// changes no state and raises overflow/underflow for exactly one cycle.
// Every output is driven from registered state only.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic             rd_ok;
  logic             wr_ok;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Accept decisions, next pointers/count, and flags derived from next count
  // so they land in the same cycle as the count itself.
  always_comb begin
    rd_ok      = rd & ~empty_q;
    wr_ok      = wr & (~full_q | rd_ok);
    mem_we     = wr_ok & ~clr;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    data_out_d = data_out_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      ovf_d = wr & ~wr_ok;
      unf_d = rd & ~rd_ok;
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (FWFT == 0) begin
          data_out_d = mem_rdata;
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
    af_d    = (cnt_d >= AF_C);
    ae_d    = (cnt_d <= AE_C);
  end

  // State registers; reset discards occupancy immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      data_out_q <= data_out_d;
    end
  end

  // In FWFT mode the head word is shown straight from storage, gated to zero
  // while empty; both terms come from registered state.
  assign data_out     = (FWFT != 0) ? (empty_q ? '0 : mem_rdata) : data_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
